// File: rtl/clock_set_ctrl.sv
`default_nettype none
// clock_set_ctrl: mode sequencer for the digital clock/alarm. Turns debounced
// buttons into time-set loads for the counter chain, holds the alarm time and drives the buzzer.
module clock_set_ctrl #(
  parameter int ADJ_HOLD   = 250000,
  parameter int RING_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alm,
  input  logic [1:0] hourTens,
  input  logic [3:0] hourUnits,
  input  logic [2:0] minTens,
  input  logic [3:0] minUnits,
  input  logic [2:0] secTens,
  input  logic [3:0] secUnits,
  output logic       adj,
  output logic [1:0] hourtens_adj,
  output logic [3:0] hourunits_adj,
  output logic [2:0] mintens_adj,
  output logic [3:0] minunits_adj,
  output logic [1:0] alm_ht,
  output logic [3:0] alm_hu,
  output logic [2:0] alm_mt,
  output logic [3:0] alm_mu,
  output logic       alarm_en,
  output logic       buzzer,
  output logic [3:0] mode
);

  localparam int HOLD_W = $clog2(ADJ_HOLD + 1);
  localparam int RING_W = $clog2(RING_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ADJ_HOLD);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TICKS);

  localparam logic [3:0] S_RUN    = 4'd0;
  localparam logic [3:0] S_SET_HT = 4'd1;
  localparam logic [3:0] S_SET_HU = 4'd2;
  localparam logic [3:0] S_SET_MT = 4'd3;
  localparam logic [3:0] S_SET_MU = 4'd4;
  localparam logic [3:0] S_ALM_HT = 4'd5;
  localparam logic [3:0] S_ALM_HU = 4'd6;
  localparam logic [3:0] S_ALM_MT = 4'd7;
  localparam logic [3:0] S_ALM_MU = 4'd8;

  // Time groups are packed {HT[1:0], HU[3:0], MT[2:0], MU[3:0]}.
  logic [3:0]        state_q, state_d;
  logic [12:0]       edit_q, edit_d;
  logic [12:0]       alm_q, alm_d;
  logic              alarm_en_q, alarm_en_d;
  logic              buzzer_q, buzzer_d;
  logic              adj_q, adj_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic              match_prev_q;

  logic [12:0] live_w;
  logic        in_set_w;
  logic        in_alm_w;
  logic        next_set_w;
  logic [1:0]  sel_w;
  logic        match_w;
  logic        ring_start_w;

  function automatic logic [12:0] bump_digit(input logic [1:0] sel, input logic [12:0] t);
    logic [1:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
    {ht, hu, mt, mu} = t;
    case (sel)
      2'd0: begin
        ht = (ht >= 2'd2) ? 2'd0 : ht + 2'd1;
        if (ht == 2'd2 && hu > 4'd3) hu = 4'd3;
      end
      2'd1: begin
        if (hu >= ((ht == 2'd2) ? 4'd3 : 4'd9)) hu = 4'd0;
        else hu = hu + 4'd1;
      end
      2'd2:    mt = (mt >= 3'd5) ? 3'd0 : mt + 3'd1;
      default: mu = (mu >= 4'd9) ? 4'd0 : mu + 4'd1;
    endcase
    return {ht, hu, mt, mu};
  endfunction

  assign live_w   = {hourTens, hourUnits, minTens, minUnits};
  assign in_set_w = (state_q >= S_SET_HT) && (state_q <= S_SET_MU);
  assign in_alm_w = (state_q >= S_ALM_HT) && (state_q <= S_ALM_MU);

  always_comb begin
    sel_w = 2'd0;
    case (state_q)
      S_SET_HU, S_ALM_HU: sel_w = 2'd1;
      S_SET_MT, S_ALM_MT: sel_w = 2'd2;
      S_SET_MU, S_ALM_MU: sel_w = 2'd3;
      default:            sel_w = 2'd0;
    endcase
  end

  assign match_w = (state_q == S_RUN) && alarm_en_q && (live_w == alm_q) &&
                   (secTens == 3'd0) && (secUnits == 4'd0);
  assign ring_start_w = match_w && !match_prev_q;

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    alm_d      = alm_q;
    alarm_en_d = alarm_en_q;
    buzzer_d   = buzzer_q;
    ring_d     = ring_q;
    hold_d     = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;

    if (buzzer_q && tick) begin
      ring_d = ring_q + RING_W'(1);
      if (ring_q + RING_W'(1) == RING_LAST) buzzer_d = 1'b0;
    end
    if (ring_start_w) begin
      buzzer_d = 1'b1;
      ring_d   = '0;
    end

    if (btn_mode) begin
      case (state_q)
        S_RUN: begin
          state_d = S_SET_HT;
          edit_d  = live_w;
          hold_d  = '0;
        end
        S_SET_HT: state_d = S_SET_HU;
        S_SET_HU: state_d = S_SET_MT;
        S_SET_MT: state_d = S_SET_MU;
        S_SET_MU: begin
          state_d = S_ALM_HT;
          hold_d  = HOLD_INIT;
        end
        S_ALM_HT: state_d = S_ALM_HU;
        S_ALM_HU: state_d = S_ALM_MT;
        S_ALM_MT: state_d = S_ALM_MU;
        default:  state_d = S_RUN;
      endcase
    end else if (btn_inc) begin
      if (in_set_w)      edit_d   = bump_digit(sel_w, edit_q);
      else if (in_alm_w) alm_d    = bump_digit(sel_w, alm_q);
      else               buzzer_d = 1'b0;
    end

    if (btn_alm && state_q == S_RUN) begin
      if (buzzer_q) begin
        buzzer_d   = 1'b0;
        alarm_en_d = 1'b0;
      end else begin
        alarm_en_d = !alarm_en_q;
      end
    end

    // The buzzer only ever sounds in RUN.
    if (state_d != S_RUN) buzzer_d = 1'b0;
  end

  assign next_set_w = (state_d >= S_SET_HT) && (state_d <= S_SET_MU);
  assign adj_d      = next_set_w || (hold_d != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RUN;
      edit_q       <= '0;
      alm_q        <= '0;
      alarm_en_q   <= 1'b0;
      buzzer_q     <= 1'b0;
      adj_q        <= 1'b0;
      hold_q       <= '0;
      ring_q       <= '0;
      match_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      alm_q        <= alm_d;
      alarm_en_q   <= alarm_en_d;
      buzzer_q     <= buzzer_d;
      adj_q        <= adj_d;
      hold_q       <= hold_d;
      ring_q       <= ring_d;
      match_prev_q <= match_w;
    end
  end

  assign adj = adj_q;
  assign {hourtens_adj, hourunits_adj, mintens_adj, minunits_adj} = edit_q;
  assign {alm_ht, alm_hu, alm_mt, alm_mu} = alm_q;
  assign alarm_en = alarm_en_q;
  assign buzzer   = buzzer_q;

  // Bit order {ringing, ALM, SET, RUN}; ringing displaces the RUN indication.
  assign mode = buzzer_q ? 4'b1000 : {1'b0, in_alm_w, in_set_w, state_q == S_RUN};

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// tb_clock_set_ctrl: directed scoreboard bench for clock_set_ctrl.
// Stimulus queues expected outputs; a negedge monitor pops and compares them.
module tb_clock_set_ctrl;

  logic       clk, reset, tick, btn_mode, btn_inc, btn_alm;
  logic [1:0] hourTens;
  logic [3:0] hourUnits;
  logic [2:0] minTens;
  logic [3:0] minUnits;
  logic [2:0] secTens;
  logic [3:0] secUnits;
  logic       adj, alarm_en, buzzer;
  logic [1:0] hourtens_adj, alm_ht;
  logic [3:0] hourunits_adj, minunits_adj, alm_hu, alm_mu;
  logic [2:0] mintens_adj, alm_mt;
  logic [3:0] mode;

  localparam int SEL_MODE = 0, SEL_ADJ = 1, SEL_EDIT = 2, SEL_ALM = 3, SEL_EN = 4, SEL_BUZ = 5;
  localparam int B_MODE = 0, B_INC = 1, B_ALM = 2;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   ntot  = 0;

  clock_set_ctrl #(.ADJ_HOLD(8), .RING_TICKS(60)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alm(btn_alm),
    .hourTens(hourTens), .hourUnits(hourUnits), .minTens(minTens),
    .minUnits(minUnits), .secTens(secTens), .secUnits(secUnits),
    .adj(adj), .hourtens_adj(hourtens_adj), .hourunits_adj(hourunits_adj),
    .mintens_adj(mintens_adj), .minunits_adj(minunits_adj),
    .alm_ht(alm_ht), .alm_hu(alm_hu), .alm_mt(alm_mt), .alm_mu(alm_mu),
    .alarm_en(alarm_en), .buzzer(buzzer), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every queued expectation is compared at the next falling edge.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.sel)
          SEL_MODE: act = {12'd0, mode};
          SEL_ADJ:  act = {15'd0, adj};
          SEL_EDIT: act = {3'd0, hourtens_adj, hourunits_adj, mintens_adj, minunits_adj};
          SEL_ALM:  act = {3'd0, alm_ht, alm_hu, alm_mt, alm_mu};
          SEL_EN:   act = {15'd0, alarm_en};
          default:  act = {15'd0, buzzer};
        endcase
        ntot++;
        if (act === e.exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_sig(input string nm, input int sel, input logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic expect_time(input string nm, input int sel, input logic [1:0] ht,
                             input logic [3:0] hu, input logic [2:0] mt, input logic [3:0] mu);
    expect_sig(nm, sel, {3'd0, ht, hu, mt, mu});
  endtask

  task automatic flush();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      ntot++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic press(input int which, input int times);
    for (int i = 0; i < times; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      case (which)
        B_MODE:  btn_mode = 1'b1;
        B_INC:   btn_inc  = 1'b1;
        default: btn_alm  = 1'b1;
      endcase
      @(posedge clk);
      #1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_alm  = 1'b0;
    end
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_live(input logic [1:0] ht, input logic [3:0] hu, input logic [2:0] mt,
                          input logic [3:0] mu, input logic [2:0] st, input logic [3:0] su);
    hourTens = ht; hourUnits = hu; minTens = mt; minUnits = mu; secTens = st; secUnits = su;
  endtask

  // Alarm is 06:30; drop the match for a while then restore it to start a fresh ring.
  task automatic retrigger(input string nm);
    minUnits = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    minUnits = 4'd0;
    @(posedge clk);
    #1;
    expect_sig(nm, SEL_BUZ, 16'd1);
    flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_alm = 1'b0;
    set_live(2'd1, 4'd8, 3'd4, 4'd7, 3'd0, 4'd5);
    repeat (3) @(posedge clk);
    #1;
    expect_sig("rst_mode", SEL_MODE, 16'h1);
    expect_sig("rst_adj", SEL_ADJ, 16'd0);
    expect_time("rst_edit", SEL_EDIT, 2'd0, 4'd0, 3'd0, 4'd0);
    expect_time("rst_alarm", SEL_ALM, 2'd0, 4'd0, 3'd0, 4'd0);
    expect_sig("rst_alarm_en", SEL_EN, 16'd0);
    expect_sig("rst_buzzer", SEL_BUZ, 16'd0);
    flush();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Set pass from live 18:47: HT bump clamps HU, MU wraps through 9.
    press(B_MODE, 1);
    expect_time("enter_set_edit", SEL_EDIT, 2'd1, 4'd8, 3'd4, 4'd7);
    expect_sig("enter_set_adj", SEL_ADJ, 16'd1);
    expect_sig("enter_set_mode", SEL_MODE, 16'h2);
    flush();
    press(B_INC, 1);
    expect_time("ht_inc_clamp", SEL_EDIT, 2'd2, 4'd3, 3'd4, 4'd7);
    flush();
    press(B_MODE, 3);
    press(B_INC, 3);
    expect_time("mu_inc_wrap", SEL_EDIT, 2'd2, 4'd3, 3'd4, 4'd0);
    flush();
    press(B_MODE, 1);
    expect_sig("alm_ht_mode", SEL_MODE, 16'h4);
    for (int i = 0; i <= 8; i++) begin
      expect_sig($sformatf("adj_hold_%0d", i), SEL_ADJ, (i < 8) ? 16'd1 : 16'd0);
      flush();
    end

    // Alarm to 06:30; btn_alm outside RUN must be ignored.
    press(B_MODE, 1);
    press(B_INC, 6);
    press(B_MODE, 1);
    press(B_INC, 3);
    press(B_ALM, 1);
    expect_sig("alm_btn_in_alm_mt", SEL_EN, 16'd0);
    flush();
    press(B_MODE, 1);
    expect_time("alarm_regs", SEL_ALM, 2'd0, 4'd6, 3'd3, 4'd0);
    flush();
    press(B_MODE, 1);
    expect_sig("back_run_mode", SEL_MODE, 16'h1);
    expect_sig("back_run_adj", SEL_ADJ, 16'd0);
    flush();
    press(B_ALM, 1);
    expect_sig("arm_alarm", SEL_EN, 16'd1);
    flush();

    // Match at 06:30:00 rings one edge later, only once, for 60 ticks.
    @(posedge clk);
    #1;
    set_live(2'd0, 4'd6, 3'd3, 4'd0, 3'd0, 4'd0);
    expect_sig("ring_before_edge", SEL_BUZ, 16'd0);
    flush();
    expect_sig("ring_start", SEL_BUZ, 16'd1);
    flush();
    repeat (5) @(posedge clk);
    #1;
    send_ticks(59);
    expect_sig("ring_59_ticks", SEL_BUZ, 16'd1);
    flush();
    send_ticks(1);
    expect_sig("ring_60_ticks", SEL_BUZ, 16'd0);
    flush();
    repeat (6) @(posedge clk);
    #1;
    expect_sig("no_refire", SEL_BUZ, 16'd0);
    flush();

    retrigger("ring2_start");
    press(B_INC, 1);
    expect_sig("inc_dismiss_buz", SEL_BUZ, 16'd0);
    expect_sig("inc_dismiss_en", SEL_EN, 16'd1);
    expect_sig("inc_dismiss_mode", SEL_MODE, 16'h1);
    expect_time("inc_in_run_edit", SEL_EDIT, 2'd2, 4'd3, 3'd4, 4'd0);
    flush();

    retrigger("ring3_start");
    press(B_MODE, 1);
    expect_sig("mode_dismiss_buz", SEL_BUZ, 16'd0);
    expect_sig("mode_dismiss_mode", SEL_MODE, 16'h2);
    expect_time("mode_dismiss_edit", SEL_EDIT, 2'd0, 4'd6, 3'd3, 4'd0);
    flush();
    minUnits = 4'd1;
    press(B_MODE, 8);
    expect_sig("loop_back_run", SEL_MODE, 16'h1);
    flush();

    retrigger("ring4_start");
    press(B_ALM, 1);
    expect_sig("alm_dismiss_buz", SEL_BUZ, 16'd0);
    expect_sig("alm_dismiss_en", SEL_EN, 16'd0);
    flush();

    // Second set pass from 19:57: HU 9 wraps with HT=1, MT 5 wraps.
    set_live(2'd1, 4'd9, 3'd5, 4'd7, 3'd0, 4'd0);
    press(B_MODE, 1);
    expect_time("pass2_load", SEL_EDIT, 2'd1, 4'd9, 3'd5, 4'd7);
    flush();
    press(B_MODE, 1);
    press(B_INC, 1);
    expect_time("hu_wrap_9", SEL_EDIT, 2'd1, 4'd0, 3'd5, 4'd7);
    flush();
    press(B_MODE, 1);
    press(B_INC, 1);
    expect_time("mt_wrap_5", SEL_EDIT, 2'd1, 4'd0, 3'd0, 4'd7);
    flush();
    press(B_MODE, 4);
    press(B_ALM, 1);
    expect_sig("alm_btn_ignored", SEL_EN, 16'd0);
    expect_time("alarm_kept", SEL_ALM, 2'd0, 4'd6, 3'd3, 4'd0);
    flush();
    press(B_MODE, 2);
    repeat (10) @(posedge clk);
    #1;

    // Third pass from 23:15: mode+inc together, then HU 3 wraps with HT=2.
    set_live(2'd2, 4'd3, 3'd1, 4'd5, 3'd0, 4'd0);
    press(B_MODE, 1);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    expect_time("mode_inc_same_edit", SEL_EDIT, 2'd2, 4'd3, 3'd1, 4'd5);
    expect_sig("mode_inc_same_mode", SEL_MODE, 16'h2);
    flush();
    press(B_INC, 1);
    expect_time("hu_wrap_3", SEL_EDIT, 2'd2, 4'd0, 3'd1, 4'd5);
    flush();
    press(B_MODE, 1);
    expect_sig("set_mt_adj", SEL_ADJ, 16'd1);
    flush();

    // Asynchronous reset in SET_MT, sampled before any further clock edge.
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    expect_sig("arst_mode", SEL_MODE, 16'h1);
    expect_sig("arst_adj", SEL_ADJ, 16'd0);
    expect_time("arst_alarm", SEL_ALM, 2'd0, 4'd0, 3'd0, 4'd0);
    expect_time("arst_edit", SEL_EDIT, 2'd0, 4'd0, 3'd0, 4'd0);
    expect_sig("arst_buzzer", SEL_BUZ, 16'd0);
    flush();
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
